neural_spike_frame: RTL and testbench

- Consumer at the far end of the neural dataset simulator stream.
- Takes signed 12-bit ADC samples with a per-sample valid strobe, a ground-truth spike trigger and an end-of-data flag.
- Detects spikes with an absolute-amplitude threshold and captures a fixed pre/post-trigger window in a circular buffer.
- Streams each captured frame out over a valid/ready handshake, oldest sample first, for spike-sorting or logging.

---
 rtl/neural_spike_frame_if.sv | 28 ++
 rtl/neural_spike_frame.sv | 142 ++++++++++++++
 tb/tb_neural_spike_frame.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/neural_spike_frame_if.sv
// neural_spike_frame_if: sample input stream, frame output stream and status bundle
interface neural_spike_frame_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16
);
  logic                     EN;
  logic [DATA_W-2:0]        THR;
  logic signed [DATA_W-1:0] DATA_IN;
  logic                     DATA_VLD;
  logic                     TRGG_IN;
  logic                     DATA_END_IN;
  logic [DATA_W-1:0]        FRAME_DATA;
  logic                     FRAME_TRGG;
  logic                     FRAME_VLD;
  logic                     FRAME_RDY;
  logic                     FRAME_LAST;
  logic [CNT_W-1:0]         SPIKE_CNT;
  logic [CNT_W-1:0]         DROP_CNT;
  logic                     DONE;
  modport master (
    output EN, THR, DATA_IN, DATA_VLD, TRGG_IN, DATA_END_IN, FRAME_RDY,
    input  FRAME_DATA, FRAME_TRGG, FRAME_VLD, FRAME_LAST, SPIKE_CNT, DROP_CNT, DONE
  );
  modport slave (
    input  EN, THR, DATA_IN, DATA_VLD, TRGG_IN, DATA_END_IN, FRAME_RDY,
    output FRAME_DATA, FRAME_TRGG, FRAME_VLD, FRAME_LAST, SPIKE_CNT, DROP_CNT, DONE
  );
endinterface

// File: rtl/neural_spike_frame.sv
// neural_spike_frame: threshold spike detector capturing a pre/post-trigger window and streaming it out
module neural_spike_frame #(
  parameter int DATA_W     = 12,
  parameter int LOG2_FRAME = 5,
  parameter int PRE_LEN    = 8,
  parameter int CNT_W      = 16
) (
  input logic              CLK_ADC,
  input logic              RST,
  neural_spike_frame_if.slave bus
);
  localparam int FRAME_LEN = 1 << LOG2_FRAME;
  localparam int POST_N    = FRAME_LEN - PRE_LEN - 1;
  typedef enum logic [2:0] {IDLE, FILL, ARM, POST, SEND, FINISH} state_t;
  state_t                state_q, state_d;
  logic [LOG2_FRAME-1:0] wp_q, wp_d, fill_q, fill_d, post_q, post_d, start_q, start_d, rp;
  logic [LOG2_FRAME:0]   rd_q, rd_d;
  logic                  end_q, end_d, vld_q, vld_d, last_q, last_d, trgg_q, trgg_d, done_q, done_d;
  logic [DATA_W-1:0]     data_q, data_d, abs_v;
  logic [CNT_W-1:0]      spike_q, spike_d, drop_q, drop_d;
  logic [DATA_W-2:0]     mag;
  logic [DATA_W:0]       mem [FRAME_LEN];
  logic [DATA_W:0]       rd_word;
  logic                  acc, det, load;
  // next-state, detection, buffer read and output-register logic
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    fill_d  = fill_q;
    post_d  = post_q;
    start_d = start_q;
    end_d   = end_q;
    vld_d   = vld_q;
    last_d  = last_q;
    trgg_d  = trgg_q;
    data_d  = data_q;
    spike_d = spike_q;
    drop_d  = drop_q;
    abs_v   = bus.DATA_IN[DATA_W-1] ? -bus.DATA_IN : bus.DATA_IN;
    mag     = abs_v[DATA_W-1] ? '1 : abs_v[DATA_W-2:0];
    det     = mag >= bus.THR;
    acc     = bus.DATA_VLD && state_q inside {FILL, ARM, POST};
    wp_d    = acc ? wp_q + 1'b1 : wp_q;
    rd_d    = state_q == SEND ? rd_q : '0;
    rp      = start_q + rd_q[LOG2_FRAME-1:0];
    rd_word = mem[rp];
    load    = state_q == SEND && (!vld_q || bus.FRAME_RDY) && !rd_q[LOG2_FRAME];
    case (state_q)
      IDLE: if (bus.EN) begin
        state_d = FILL;
        fill_d  = '0;
      end
      FILL: if (acc) begin
        fill_d  = fill_q + 1'b1;
        state_d = fill_q == LOG2_FRAME'(PRE_LEN - 1) ? ARM : FILL;
      end
      ARM: if (acc && det && !bus.DATA_END_IN && bus.EN) begin
        spike_d = spike_q + CNT_W'(!(&spike_q));
        start_d = wp_q - LOG2_FRAME'(PRE_LEN);
        post_d  = '0;
        state_d = POST_N == 0 ? SEND : POST;
      end
      POST: if (acc) begin
        post_d  = post_q + 1'b1;
        state_d = post_q == LOG2_FRAME'(POST_N - 1) ? SEND : POST;
      end
      SEND: begin
        drop_d = bus.DATA_VLD ? drop_q + CNT_W'(!(&drop_q)) : drop_q;
        end_d  = end_q || bus.DATA_END_IN;
        vld_d  = vld_q && !bus.FRAME_RDY;
        if (load) begin
          {trgg_d, data_d} = rd_word;
          last_d = rd_q == (LOG2_FRAME+1)'(FRAME_LEN - 1);
          vld_d  = 1'b1;
          rd_d   = rd_q + 1'b1;
        end
        if (vld_q && bus.FRAME_RDY && last_q) begin
          state_d = (end_q || bus.DATA_END_IN) ? FINISH : FILL;
          fill_d  = '0;
          end_d   = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: ;
    endcase
    if (bus.DATA_END_IN && state_q inside {FILL, ARM, POST}) state_d = FINISH;
    if (!bus.EN && state_q != IDLE) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      last_d  = 1'b0;
      trgg_d  = 1'b0;
      data_d  = '0;
      end_d   = 1'b0;
    end
    done_d = state_d == FINISH;
  end
  // sample history buffer; contents need no reset because reads only follow fresh writes
  always_ff @(posedge CLK_ADC) begin
    if (acc) mem[wp_q] <= {bus.TRGG_IN, bus.DATA_IN};
  end
  // control state, pointers, output register and statistics
  always_ff @(posedge CLK_ADC) begin
    if (RST) begin
      state_q <= IDLE;
      wp_q    <= '0;
      fill_q  <= '0;
      post_q  <= '0;
      start_q <= '0;
      rd_q    <= '0;
      end_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      trgg_q  <= 1'b0;
      data_q  <= '0;
      spike_q <= '0;
      drop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      fill_q  <= fill_d;
      post_q  <= post_d;
      start_q <= start_d;
      rd_q    <= rd_d;
      end_q   <= end_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      trgg_q  <= trgg_d;
      data_q  <= data_d;
      spike_q <= spike_d;
      drop_q  <= drop_d;
      done_q  <= done_d;
    end
  end
  assign bus.FRAME_DATA = data_q;
  assign bus.FRAME_TRGG = trgg_q;
  assign bus.FRAME_VLD  = vld_q;
  assign bus.FRAME_LAST = last_q;
  assign bus.SPIKE_CNT  = spike_q;
  assign bus.DROP_CNT   = drop_q;
  assign bus.DONE       = done_q;
endmodule

// File: tb/tb_neural_spike_frame.sv
// tb_neural_spike_frame: scoreboard bench for frame capture, handshake, drops, end-of-data and aborts
module tb_neural_spike_frame;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  neural_spike_frame_if bus ();
  neural_spike_frame dut (.CLK_ADC(clk), .RST(rst), .bus(bus));
  typedef struct packed {logic last; logic trgg; logic [11:0] data;} ent_t;
  ent_t sb[$];
  ent_t prev, mon_e;
  logic stall_prev = 1'b0;
  int   errors = 0, checks = 0, xfers = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [11:0] d, input logic t, input logic l);
    sb.push_back({l, t, d});
  endtask
  task automatic push_ramp();
    for (int k = 0; k < 32; k++) push(12'(192 + k), k == 3, k == 31);
  endtask
  task automatic smp(input logic [11:0] d, input logic t);
    bus.DATA_IN  = d;
    bus.TRGG_IN  = t;
    bus.DATA_VLD = 1'b1;
    tick();
  endtask
  task automatic ramp(input int last_n, input int end_at);
    for (int i = 0; i <= last_n; i++) begin
      bus.DATA_END_IN = (i == end_at);
      smp(12'(i), i == 195);
    end
    bus.DATA_VLD    = 1'b0;
    bus.DATA_END_IN = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n < 200 && sb.size() > 0; n++) tick();
    chk("drain", sb.size(), 0);
  endtask
  task automatic restart(input logic [10:0] thr);
    rst             = 1'b1;
    bus.EN          = 1'b0;
    bus.DATA_VLD    = 1'b0;
    bus.DATA_END_IN = 1'b0;
    bus.TRGG_IN     = 1'b0;
    bus.FRAME_RDY   = 1'b0;
    bus.THR         = thr;
    tick();
    sb.delete();
    rst    = 1'b0;
    bus.EN = 1'b1;
    tick();
    xfers = 0;
  endtask
  // output monitor: pops the scoreboard on each transfer and checks stall stability
  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev) begin
        chk("hold_vld", bus.FRAME_VLD, 1);
        chk("hold_data", {bus.FRAME_LAST, bus.FRAME_TRGG, bus.FRAME_DATA}, prev);
      end
      if (bus.FRAME_VLD && bus.FRAME_RDY) begin
        xfers++;
        chk("sb_avail", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("data", bus.FRAME_DATA, mon_e.data);
          chk("trgg", bus.FRAME_TRGG, mon_e.trgg);
          chk("last", bus.FRAME_LAST, mon_e.last);
        end
      end
      stall_prev = bus.FRAME_VLD && !bus.FRAME_RDY;
      prev       = {bus.FRAME_LAST, bus.FRAME_TRGG, bus.FRAME_DATA};
    end
  end
  initial begin
    logic stalled;
    bus.EN = 1'b0; bus.THR = '0; bus.DATA_IN = '0; bus.DATA_VLD = 1'b0;
    bus.TRGG_IN = 1'b0; bus.DATA_END_IN = 1'b0; bus.FRAME_RDY = 1'b0;
    repeat (2) tick();
    chk("rst_vld", bus.FRAME_VLD, 0);
    chk("rst_data", bus.FRAME_DATA, 0);
    chk("rst_last", bus.FRAME_LAST, 0);
    chk("rst_spike", bus.SPIKE_CNT, 0);
    chk("rst_done", bus.DONE, 0);
    restart(11'd200);
    bus.FRAME_RDY = 1'b1;
    push_ramp();
    ramp(223, -1);
    drain();
    chk("ramp_spike", bus.SPIKE_CNT, 1);
    chk("ramp_drop", bus.DROP_CNT, 0);
    chk("ramp_xfers", xfers, 32);
    restart(11'd200);
    push_ramp();
    ramp(223, -1);
    stalled = 1'b0;
    for (int n = 0; n < 300 && sb.size() > 0; n++) begin
      if (xfers == 10 && !stalled) begin
        bus.FRAME_RDY = 1'b0;
        repeat (5) tick();
        stalled = 1'b1;
      end else begin
        bus.FRAME_RDY = !bus.FRAME_RDY;
        tick();
      end
    end
    chk("bp_empty", sb.size(), 0);
    chk("bp_xfers", xfers, 32);
    restart(11'd200);
    push_ramp();
    ramp(223, -1);
    for (int i = 0; i < 40; i++) smp(12'(224 + i), 1'b0);
    bus.DATA_VLD = 1'b0;
    chk("drop_cnt", bus.DROP_CNT, 40);
    bus.FRAME_RDY = 1'b1;
    drain();
    for (int k = 12; k < 44; k++) push(k == 20 ? 12'd300 : 12'(k), k == 20, k == 43);
    for (int k = 0; k < 44; k++) smp(k == 20 ? 12'd300 : 12'(k), k == 20);
    bus.DATA_VLD = 1'b0;
    drain();
    chk("wrap_spike", bus.SPIKE_CNT, 2);
    chk("wrap_drop", bus.DROP_CNT, 40);
    restart(11'd2047);
    for (int k = 0; k < 32; k++) push(k == 7 ? 12'd2046 : k == 8 ? 12'h800 : 12'd0, k == 8, k == 31);
    repeat (8) smp(12'd0, 1'b0);
    smp(12'd2046, 1'b0);
    chk("sat_2046", bus.SPIKE_CNT, 0);
    smp(12'h800, 1'b1);
    chk("sat_m2048", bus.SPIKE_CNT, 1);
    repeat (23) smp(12'd0, 1'b0);
    bus.DATA_VLD  = 1'b0;
    bus.FRAME_RDY = 1'b1;
    drain();
    repeat (8) smp(12'd0, 1'b0);
    smp(12'h801, 1'b0);
    bus.DATA_VLD = 1'b0;
    chk("sat_m2047", bus.SPIKE_CNT, 2);
    restart(11'd200);
    bus.FRAME_RDY = 1'b1;
    ramp(210, 210);
    chk("end_post_done", bus.DONE, 1);
    chk("end_post_vld", bus.FRAME_VLD, 0);
    repeat (5) tick();
    chk("end_post_stay", bus.DONE, 1);
    chk("end_post_novld", bus.FRAME_VLD, 0);
    chk("end_post_spike", bus.SPIKE_CNT, 1);
    bus.EN = 1'b0;
    tick();
    chk("end_en_clr", bus.DONE, 0);
    restart(11'd200);
    push_ramp();
    ramp(223, -1);
    tick();
    bus.DATA_END_IN = 1'b1;
    tick();
    bus.DATA_END_IN = 1'b0;
    chk("end_send_busy", bus.DONE, 0);
    chk("end_send_vld", bus.FRAME_VLD, 1);
    bus.FRAME_RDY = 1'b1;
    drain();
    chk("end_send_done", bus.DONE, 1);
    chk("end_send_xfers", xfers, 32);
    chk("end_send_novld", bus.FRAME_VLD, 0);
    restart(11'd200);
    push_ramp();
    ramp(223, -1);
    bus.FRAME_RDY = 1'b1;
    for (int n = 0; n < 100 && xfers < 12; n++) tick();
    chk("abort_idx", xfers, 12);
    chk("abort_cur", bus.FRAME_DATA, 204);
    rst = 1'b1;
    tick();
    chk("abort_vld", bus.FRAME_VLD, 0);
    chk("abort_data", bus.FRAME_DATA, 0);
    chk("abort_last", bus.FRAME_LAST, 0);
    chk("abort_trgg", bus.FRAME_TRGG, 0);
    chk("abort_spike", bus.SPIKE_CNT, 0);
    chk("abort_drop", bus.DROP_CNT, 0);
    chk("abort_done", bus.DONE, 0);
    sb.delete();
    restart(11'd200);
    bus.FRAME_RDY = 1'b1;
    push_ramp();
    ramp(223, -1);
    drain();
    repeat (10) smp(12'd5, 1'b0);
    bus.DATA_VLD = 1'b0;
    bus.EN = 1'b0;
    tick();
    smp(12'd300, 1'b0);
    bus.DATA_VLD = 1'b0;
    tick();
    chk("en_spike_hold", bus.SPIKE_CNT, 1);
    chk("en_vld", bus.FRAME_VLD, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
